brightness_button_ctrl: RTL
===========================

Name: brightness_button_ctrl

Overview:
Upstream stage for the seven-segment PWM display path. It turns two raw pushbuttons (up/down) into the 3-bit brightness level that drives the brightness input of the BCD-to-7-segment PWM converter. Each button passes through a 2-flop synchroniser and a debouncer. The level then steps with saturation, and a held button auto-repeats. It also provides status flags for LEDs.

Parameters:
CLK_FREQ, 125_000_000, system clock frequency in Hz
DEBOUNCE_MS, 10, required stable time in ms; DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS (minimum 1)
REPEAT_DELAY_MS, 500, hold time before the first auto-repeat step; RD_CYCLES = CLK_FREQ/1000*REPEAT_DELAY_MS
REPEAT_RATE_MS, 100, interval between later repeat steps; RR_CYCLES = CLK_FREQ/1000*REPEAT_RATE_MS
RESET_LEVEL, 7, brightness level loaded on reset (0-7)

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-low reset
btn_up_raw  input  1  raw up button, asynchronous, active-high, bouncy
btn_down_raw  input  1  raw down button, asynchronous, active-high, bouncy
brightness_level  output  3  current level 0-7, registered; feeds the PWM converter
level_changed  output  1  one-cycle pulse on the cycle brightness_level takes a new value
at_max  output  1  high when brightness_level == 7
at_min  output  1  high when brightness_level == 0

Behaviour:
- Reset (reset==0 at a clk edge):
  - brightness_level=RESET_LEVEL, level_changed=0, flags decoded from RESET_LEVEL.
  - Synchronisers, debounced states and counters clear to 0; FSM goes to IDLE.
  - Reset mid-hold or mid-bounce aborts everything.
  - After reset releases, a button still held must first debounce as a new press.
- Synchroniser: 2 flops per button; no logic sees the raw inputs directly.
- Debouncer (per button):
  - The counter increments while the synchronised value differs from the debounced value, and clears to 0 the moment they agree.
  - On the cycle the counter would reach DB_CYCLES, the debounced value toggles and the counter clears.
  - Glitches shorter than DB_CYCLES never reach the debounced value.
- Press event: rising edge of the debounced value (1-cycle internal pulse). Release produces no step.
- Latency: raw input held high from edge N → brightness_level updated at edge N+DB_CYCLES+3, with level_changed high for that cycle.
- Step arithmetic:
  - up: level+1, saturating at 7.
  - down: level-1, saturating at 0.
  - No wrap. A saturated step produces no level_changed.
- Simultaneous events:
  - Press events from both buttons on the same cycle are both ignored.
  - While both debounced values are high, no steps occur (including repeats) and the FSM is forced to IDLE.
  - When one button is released, the other does not restart repeating until it is released and pressed again.
- Auto-repeat FSM (single instance; the active button is latched on entry):
  - IDLE: on a single-button press event → apply one step, load the timer with RD_CYCLES-1, go to DELAY.
  - DELAY: timer decrements each cycle.
    - Active button released → IDLE.
    - Timer==0 → one step, load the timer with RR_CYCLES-1, go to REPEAT.
  - REPEAT: on timer==0 → one step and reload with RR_CYCLES-1. Release → IDLE.
  - The other button pressing during DELAY/REPEAT is a simultaneous hold: go to IDLE with no step.
  - At saturation the repeat keeps running but produces no level change.
- at_max and at_min are combinational decodes of the registered brightness_level.

Optional Feature:
BRIGHTNESS_WRAP_EN
- Defined: steps wrap modulo 8 (7+1→0, 0-1→7) and every step produces level_changed. at_max and at_min are still decoded from the level.
- Undefined: saturating behaviour as above.

Test Plan:
Use CLK_FREQ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5 (DB=4, RD=20, RR=5), RESET_LEVEL=7.
1. Reset held low 3 cycles, then high → brightness_level=7, at_max=1, at_min=0, level_changed=0.
2. btn_down_raw high from edge 10, held 8 cycles → level 6 at edge 17, exactly one level_changed pulse. Bouncing 1-0-1-0 for 3 cycles before settling adds no extra step.
3. btn_down_raw held from level 6 → 5 at the first step; 4 at +20 cycles; then 3, 2, 1, 0 every 5 cycles; stays 0 with at_min=1 and no further level_changed.
4. btn_up_raw 3-cycle glitch (shorter than DB) → no level change.
5. Both buttons raised on the same cycle and held 40 cycles → level unchanged. Release down; up still held → no step until up is released and pressed again.
6. Reset asserted during REPEAT with the button held → level returns to 7. With the button still held after release → one step (to 6) after DB+3 cycles, then no repeat before 20 further cycles.

Source files
------------

// File: rtl/brightness_button_ctrl.sv
// brightness_button_ctrl: turns raw up/down pushbuttons into a 3-bit brightness level
// for the seven-segment PWM converter. Each button is synchronised (2 flops) and
// debounced. Presses step the level, and a held button auto-repeats.
// Optional build macro: BRIGHTNESS_WRAP_EN makes steps wrap modulo 8 instead of saturating.
module brightness_button_ctrl #(
    parameter int unsigned CLK_FREQ        = 125_000_000,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned RESET_LEVEL     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    output logic [2:0] brightness_level,
    output logic       level_changed,
    output logic       at_max,
    output logic       at_min
);

    localparam int unsigned DB_RAW    = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned RD_RAW    = CLK_FREQ / 1000 * REPEAT_DELAY_MS;
    localparam int unsigned RR_RAW    = CLK_FREQ / 1000 * REPEAT_RATE_MS;
    localparam int unsigned DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int unsigned RD_CYCLES = (RD_RAW < 1) ? 1 : RD_RAW;
    localparam int unsigned RR_CYCLES = (RR_RAW < 1) ? 1 : RR_RAW;
    localparam int unsigned TMR_MAX   = (RD_CYCLES > RR_CYCLES) ? RD_CYCLES : RR_CYCLES;
    localparam int unsigned DB_W      = $clog2(DB_CYCLES + 1);
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
    localparam int unsigned LVL_W     = 3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    // Bit 0 = up button, bit 1 = down button throughout.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db;
    logic [1:0]      db_d;
    logic [1:0]      rise_q;
    logic [DB_W-1:0] db_cnt [2];

    logic [1:0]       state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic             active, active_n;
    logic             step;
    logic             step_dn;
    logic             both_held;
    logic [LVL_W-1:0] level_n;
    logic             changed_n;

    assign btn_raw = {btn_down_raw, btn_up_raw};

    // Synchronise, debounce and detect press edges for both buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_d   <= '0;
            rise_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            db_d   <= db;
            rise_q <= db & ~db_d;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    db[i]     <= ~db[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Auto-repeat FSM state, timer and latched active button.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            timer  <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            active <= active_n;
        end
    end

    // Next-state, step request and next level computation.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        active_n  = active;
        step      = 1'b0;
        step_dn   = active;
        level_n   = brightness_level;
        changed_n = 1'b0;
        both_held = db[0] & db[1];

        case (state)
            IDLE: begin
                if (rise_q == 2'b01 || rise_q == 2'b10) begin
                    step     = 1'b1;
                    step_dn  = rise_q[1];
                    active_n = rise_q[1];
                    timer_n  = TMR_W'(RD_CYCLES - 1);
                    state_n  = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (!db[active]) begin
                    state_n = IDLE;
                end else if (timer == '0) begin
                    step    = 1'b1;
                    timer_n = TMR_W'(RR_CYCLES - 1);
                    state_n = REPEAT;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Both buttons held: no stepping of any kind, drop back to IDLE.
        if (both_held) begin
            step    = 1'b0;
            state_n = IDLE;
        end

        if (step) begin
`ifdef BRIGHTNESS_WRAP_EN
            level_n   = step_dn ? brightness_level - LVL_W'(1) : brightness_level + LVL_W'(1);
            changed_n = 1'b1;
`else
            if (step_dn && brightness_level != '0) begin
                level_n   = brightness_level - LVL_W'(1);
                changed_n = 1'b1;
            end else if (!step_dn && brightness_level != '1) begin
                level_n   = brightness_level + LVL_W'(1);
                changed_n = 1'b1;
            end
`endif
        end
    end

    // Registered brightness level and change pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            brightness_level <= LVL_W'(RESET_LEVEL);
            level_changed    <= 1'b0;
        end else begin
            brightness_level <= level_n;
            level_changed    <= changed_n;
        end
    end

    assign at_max = (brightness_level == 3'd7);
    assign at_min = (brightness_level == 3'd0);

endmodule
